// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the requester side of the round-robin
// thermometer arbiter.
package arb_req_pkg;

    // Per-client sequencer state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // Default burst-length field width (bursts of 1..16 beats)
    localparam int DEFAULT_LEN_W = 4;

    // Default starvation counter width (must exceed the timeout range)
    localparam int DEFAULT_CNT_W = 7;

    // Width of the vector accepted by is_onehot0; callers zero-extend
    localparam int ONEHOT_W = 64;

    // True when at most one bit of vec is set
    function automatic logic is_onehot0(input logic [ONEHOT_W-1:0] vec);
        return (vec & (vec - ONEHOT_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/arb_req_client.sv
// One client's request sequencer: waits for a clean grant, then owns the
// shared transfer interface for the full latched burst length. Also keeps
// the per-client starvation counter.
module arb_req_client
    import arb_req_pkg::*;
#(
    parameter int LEN_W   = DEFAULT_LEN_W,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    input  logic [LEN_W-1:0] src_len,
    input  logic             lock_busy,
    input  logic             granted,
    output logic             pending,
    output logic             owner,
    output logic             last_beat,
    output logic             starve
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           state_reg;
    logic [LEN_W-1:0] beat_cnt_reg;
    logic [CNT_W-1:0] wait_cnt_reg;

    // Client FSM: IDLE latches the burst, REQ waits and ages, XFER counts beats
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= '0;
                    if (src_valid) begin
                        state_reg    <= REQ;
                        beat_cnt_reg <= src_len;
                    end
                end
                REQ: begin
                    // A grant only counts when nobody else holds the bus
                    if (granted && !lock_busy) begin
                        state_reg    <= XFER;
                        wait_cnt_reg <= '0;
                    end else if (wait_cnt_reg != CNT_MAX) begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_ONE;
                    end
                end
                XFER: begin
                    // beat_cnt holds beats remaining minus one
                    if (beat_cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        beat_cnt_reg <= beat_cnt_reg - LEN_ONE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Status decodes taken straight from the state and counter registers
    always_comb begin
        pending   = (state_reg == REQ);
        owner     = (state_reg == XFER);
        last_beat = (state_reg == XFER) && (beat_cnt_reg == '0);
        starve    = (state_reg == REQ) && (wait_cnt_reg >= TIMEOUT_C);
    end

endmodule

// File: rtl/arb_requester.sv
// Requester-side companion to the round-robin thermometer arbiter. Builds the
// request vector from per-client bursts, locks the request onto the current
// burst owner, sequences beats onto the shared transfer interface and watches
// the arbiter for contract violations.
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int ARBITER_WIDTH = 8,
    parameter int LEN_W         = DEFAULT_LEN_W,
    parameter int TIMEOUT       = 64,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ARBITER_WIDTH-1:0]   src_valid,
    input  logic [ARBITER_WIDTH*LEN_W-1:0] src_len,
    output logic [ARBITER_WIDTH-1:0]   src_ready,
    output logic [ARBITER_WIDTH-1:0]   request,
    input  logic [ARBITER_WIDTH-1:0]   grant,
    input  logic                       any_grant,
    output logic                       xfer_valid,
    output logic [ARBITER_WIDTH-1:0]   xfer_sel,
    output logic                       xfer_last,
    output logic [ARBITER_WIDTH-1:0]   starve,
    output logic                       protocol_err
);

    logic [ARBITER_WIDTH-1:0] pending_vec;
    logic [ARBITER_WIDTH-1:0] owner_vec;
    logic [ARBITER_WIDTH-1:0] last_vec;
    logic [ARBITER_WIDTH-1:0] starve_vec;
    logic [ARBITER_WIDTH-1:0] granted_vec;
    logic                     lock_busy;
    logic                     grant_multi;
    logic                     grant_unreq;
    logic                     grant_stray;
    logic                     violation;
    logic                     protocol_err_reg;

    genvar gi;

    // One sequencer per client
    generate
        for (gi = 0; gi < ARBITER_WIDTH; gi++) begin : g_client
            arb_req_client #(
                .LEN_W   (LEN_W),
                .CNT_W   (CNT_W),
                .TIMEOUT (TIMEOUT)
            ) u_client (
                .clk       (clk),
                .reset     (reset),
                .src_valid (src_valid[gi]),
                .src_len   (src_len[gi*LEN_W +: LEN_W]),
                .lock_busy (lock_busy),
                .granted   (granted_vec[gi]),
                .pending   (pending_vec[gi]),
                .owner     (owner_vec[gi]),
                .last_beat (last_vec[gi]),
                .starve    (starve_vec[gi])
            );
        end
    endgenerate

    assign lock_busy = |owner_vec;

    // Lock masking: during a burst only the owner's bit reaches the arbiter
    always_comb begin
        if (lock_busy) begin
            request = owner_vec;
        end else begin
            request = pending_vec;
        end
    end

    // Arbiter contract checks on the grant seen this cycle
    always_comb begin
        grant_multi = !is_onehot0(ONEHOT_W'(grant));
        grant_unreq = |(grant & ~request);
        grant_stray = lock_busy && any_grant && (grant != owner_vec);
        violation   = grant_multi || grant_unreq || grant_stray;
        // A violating cycle never starts a burst; onehot0 plus the per-bit
        // request check leaves at most one clean grant bit
        granted_vec = violation ? '0 : grant;
    end

    // Sticky contract-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            protocol_err_reg <= 1'b0;
        end else if (violation) begin
            protocol_err_reg <= 1'b1;
        end
    end

    // Shared transfer interface is driven by the single burst owner
    always_comb begin
        xfer_valid   = lock_busy;
        xfer_sel     = owner_vec;
        src_ready    = owner_vec;
        xfer_last    = |last_vec;
        starve       = starve_vec;
        protocol_err = protocol_err_reg;
    end

    // Only one client may own the transfer interface at a time
    a_single_owner: assert property (@(posedge clk) disable iff (reset)
        is_onehot0(ONEHOT_W'(owner_vec)));

    // Liveness from the requester's end: a clean grant to a waiting client
    // always turns into that client's first beat on the next cycle
    generate
        for (gi = 0; gi < ARBITER_WIDTH; gi++) begin : g_live
            a_grant_starts_burst: assert property (@(posedge clk) disable iff (reset)
                (request[gi] && !lock_busy && granted_vec[gi]) |=> xfer_sel[gi]);
            c_client_served: cover property (@(posedge clk) disable iff (reset)
                request[gi] && xfer_sel[gi]);
        end
    endgenerate

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: a behavioural round-robin arbiter (or a stub),
// a burst scoreboard fed at issue time and drained by a monitor, and a
// cycle-count starvation model.
module tb_arb_requester;

    localparam int AW = 8;
    localparam int LW = 4;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [AW-1:0]     src_valid = '0;
    logic [AW*LW-1:0]  src_len = '0;
    logic [AW-1:0]     src_ready;
    logic [AW-1:0]     request;
    logic [AW-1:0]     grant;
    logic              any_grant;
    logic              xfer_valid;
    logic [AW-1:0]     xfer_sel;
    logic              xfer_last;
    logic [AW-1:0]     starve;
    logic              protocol_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    arb_requester #(
        .ARBITER_WIDTH (AW),
        .LEN_W         (LW),
        .TIMEOUT       (TO),
        .CNT_W         (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_len      (src_len),
        .src_ready    (src_ready),
        .request      (request),
        .grant        (grant),
        .any_grant    (any_grant),
        .xfer_valid   (xfer_valid),
        .xfer_sel     (xfer_sel),
        .xfer_last    (xfer_last),
        .starve       (starve),
        .protocol_err (protocol_err)
    );

    // ---------------- arbiter: round-robin model or stub ----------------
    logic          use_stub = 1'b0;
    logic [AW-1:0] stub_grant = '0;
    logic [AW-1:0] rr_grant;
    int            rr_ptr;
    int            rr_pick;

    always_comb begin
        rr_grant = '0;
        rr_pick  = -1;
        for (int k = 1; k <= AW; k++) begin
            if (rr_pick < 0 && request[(rr_ptr + k) % AW]) rr_pick = (rr_ptr + k) % AW;
        end
        if (rr_pick >= 0) rr_grant[rr_pick] = 1'b1;
    end

    assign grant     = use_stub ? stub_grant : rr_grant;
    assign any_grant = |grant;

    always @(posedge clk) begin
        if (reset) rr_ptr <= AW - 1;
        else if (!use_stub && rr_pick >= 0) rr_ptr <= rr_pick;
    end

    // ---------------- scoreboard state ----------------
    typedef struct packed {
        int client;
        int len;
    } burst_t;

    burst_t        exp_q[$];
    int            order_q[$];
    logic [AW-1:0] busy = '0;
    logic [AW-1:0] waiting = '0;
    int            wait_m[AW];
    logic          in_burst = 1'b0;
    int            beats_left = 0;
    int            owner_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Issue one burst; the pulse is sampled at the next rising edge
    task automatic issue(input int c, input int len);
        burst_t b;
        src_valid[c]        = 1'b1;
        src_len[c*LW +: LW] = LW'(len);
        busy[c]             = 1'b1;
        waiting[c]          = 1'b1;
        // first increment lands while src_valid is still being presented
        wait_m[c]           = -2;
        b.client = c;
        b.len    = len;
        exp_q.push_back(b);
        $display("[TB] issue client %0d len %0d", c, len);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        src_valid = '0;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        src_valid  = '0;
        use_stub   = 1'b0;
        stub_grant = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (busy != '0 && n < budget) begin
            step();
            n++;
        end
        check(name, busy, '0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int            idx;
        logic [AW-1:0] exp_sel;
        logic [AW-1:0] exp_starve;
        if (reset) begin
            exp_q.delete();
            order_q.delete();
            busy       = '0;
            waiting    = '0;
            in_burst   = 1'b0;
            beats_left = 0;
            owner_m    = 0;
        end else begin
            if (xfer_valid) begin
                if (!in_burst) begin
                    check("sel_onehot", $onehot(xfer_sel), 1);
                    for (int i = AW - 1; i >= 0; i--) if (xfer_sel[i]) owner_m = i;
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (idx < 0 && exp_q[j].client == owner_m) idx = j;
                    check("burst_expected", idx >= 0, 1);
                    if (idx >= 0) begin
                        beats_left = exp_q[idx].len + 1;
                        exp_q.delete(idx);
                    end else begin
                        beats_left = 1;
                    end
                    in_burst         = 1'b1;
                    waiting[owner_m] = 1'b0;
                    order_q.push_back(owner_m);
                end
                exp_sel = '0;
                exp_sel[owner_m] = 1'b1;
                check("xfer_sel", xfer_sel, exp_sel);
                check("src_ready", src_ready, exp_sel);
                check("lock_request", request, exp_sel);
                beats_left--;
                check("xfer_last", xfer_last, beats_left == 0);
                $display("[TB] beat client %0d remaining %0d last %0b", owner_m, beats_left, xfer_last);
                if (beats_left <= 0) begin
                    in_burst      = 1'b0;
                    busy[owner_m] = 1'b0;
                end
            end else begin
                check("burst_gap", in_burst, 0);
                in_burst = 1'b0;
                check("idle_ready", src_ready, '0);
                check("idle_last", xfer_last, 0);
            end
            exp_starve = '0;
            for (int i = 0; i < AW; i++) begin
                if (waiting[i]) begin
                    wait_m[i]++;
                    if (wait_m[i] >= TO) exp_starve[i] = 1'b1;
                end
            end
            check("starve", starve, exp_starve);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int mask;
        int nb;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_request", request, '0);
        check("rst_src_ready", src_ready, '0);
        check("rst_xfer_valid", xfer_valid, 0);
        check("rst_xfer_sel", xfer_sel, '0);
        check("rst_xfer_last", xfer_last, 0);
        check("rst_starve", starve, '0);
        check("rst_protocol_err", protocol_err, 0);
        @(posedge clk);
        #1;

        // Single-client burst, len field 3
        issue(2, 3);
        step();
        @(negedge clk);
        check("single_request", request, 8'h04);
        check("single_no_beat_yet", xfer_valid, 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            check("single_sel", xfer_sel, 8'h04);
            check("single_ready", src_ready, 8'h04);
            check("single_last", xfer_last, b == 3);
        end
        @(negedge clk);
        check("single_done", xfer_valid, 0);
        @(posedge clk);
        #1;

        // Lock masking: clients 1 and 5 together, 8 beats each
        issue(1, 7);
        issue(5, 7);
        step();
        wait_drain(60, "lock_drain");
        check("lock_pair", (order_q.size() >= 2) ?
              ((1 << order_q[order_q.size()-1]) | (1 << order_q[order_q.size()-2])) : 0, 8'h22);
        check("lock_perr", protocol_err, 0);

        // Starvation with the arbiter held silent
        do_reset();
        use_stub = 1'b1;
        issue(0, 2);
        step();
        repeat (63) @(posedge clk);
        @(negedge clk);
        check("starve_before", starve, 8'h00);
        @(negedge clk);
        check("starve_at_timeout", starve, 8'h01);
        stub_grant = 8'h01;
        @(negedge clk);
        check("starve_cleared", starve, 8'h00);
        check("starve_burst_start", xfer_sel, 8'h01);
        stub_grant = 8'h00;
        @(posedge clk);
        #1;
        wait_drain(20, "starve_drain");
        check("starve_perr", protocol_err, 0);

        // Multiple grants
        do_reset();
        use_stub = 1'b1;
        issue(0, 0);
        issue(1, 0);
        step();
        stub_grant = 8'h03;
        @(negedge clk);
        check("multi_perr_before", protocol_err, 0);
        @(negedge clk);
        check("multi_perr", protocol_err, 1);
        check("multi_no_xfer", xfer_valid, 0);
        stub_grant = 8'h00;
        repeat (5) @(negedge clk);
        check("multi_perr_sticky", protocol_err, 1);
        check("multi_still_no_xfer", xfer_valid, 0);

        // Grant without request
        do_reset();
        use_stub   = 1'b1;
        stub_grant = 8'h10;
        @(negedge clk);
        check("unreq_perr_before", protocol_err, 0);
        @(negedge clk);
        check("unreq_perr", protocol_err, 1);
        stub_grant = 8'h00;

        // Reset on the 2nd beat of a 16-beat burst
        do_reset();
        issue(3, 15);
        step();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!xfer_valid && n < 20);
        check("mid_first_beat", xfer_sel, 8'h08);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("mid_second_beat", {xfer_sel, xfer_last}, {8'h08, 1'b0});
        @(posedge clk);
        @(negedge clk);
        check("mid_outputs_cleared",
              {request, src_ready, xfer_sel, starve, xfer_valid, xfer_last, protocol_err}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        issue(6, 1);
        step();
        wait_drain(20, "mid_post_reset_drain");
        check("mid_post_reset_owner", (order_q.size() == 1) ? order_q[0] : -1, 6);

        // Randomised traffic against the round-robin arbiter
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < AW; c++)
                if (!busy[c] && $urandom_range(0, 3) == 0) issue(c, int'($urandom_range(0, 15)));
            step();
        end
        wait_drain(3000, "random_drain");
        check("random_queue_empty", exp_q.size(), 0);
        check("random_perr", protocol_err, 0);

        // Fairness: every client always valid, single-beat bursts
        do_reset();
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int c = 0; c < AW; c++)
                if (!busy[c]) issue(c, 0);
            step();
        end
        wait_drain(100, "fair_drain");
        nb = order_q.size() / AW;
        check("fair_enough_bursts", nb >= 10, 1);
        for (int b = 0; b < nb; b++) begin
            mask = 0;
            for (int k = 0; k < AW; k++) mask = mask | (1 << order_q[b*AW + k]);
            check("fair_block", mask, 8'hFF);
        end
        check("fair_perr", protocol_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time bound for the whole run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
